// File: rtl/amacv2_axil_arbiter.sv
// amacv2_axil_arbiter: two requesters share one AXI4-Lite master port.
// Round-robin grant, one AXI transaction in flight at a time, and a one-cycle
// completion pulse back to the requester that was granted.
module amacv2_axil_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  // requester side
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  // AXI4-Lite write address channel
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  // AXI4-Lite write data channel
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  // AXI4-Lite write response channel
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  // AXI4-Lite read address channel
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  // AXI4-Lite read data channel
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, RSP} state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic                    last_q;
  logic                    gnt_q;
  logic                    pick;
  logic                    grant;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    aw_vld_q;
  logic                    w_vld_q;
  logic                    ar_vld_q;
  logic                    aw_fin;
  logic                    w_fin;

  assign M_AXI_AWVALID = aw_vld_q;
  assign M_AXI_WVALID  = w_vld_q;
  assign M_AXI_ARVALID = ar_vld_q;

  // A write channel counts as finished once its handshake happened earlier
  // or is happening in the current cycle.
  assign aw_fin = ~aw_vld_q | M_AXI_AWREADY;
  assign w_fin  = ~w_vld_q  | M_AXI_WREADY;

  // Round-robin choice: a lone valid requester wins, a tie goes to the
  // requester that was not served last.
  always_comb begin
    pick = req_valid[1];
    if (req_valid == 2'b11) pick = ~last_q;
    sel_we    = req_we[pick];
    sel_addr  = pick ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
    sel_wdata = pick ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
  end

  // Next-state and handshake strobes; req_ready is held low while in reset.
  always_comb begin
    state_d      = state_q;
    grant        = 1'b0;
    req_ready    = 2'b00;
    rsp_valid    = 2'b00;
    M_AXI_BREADY = 1'b0;
    M_AXI_RREADY = 1'b0;
    case (state_q)
      IDLE: begin
        if (ARESETN && (req_valid != 2'b00)) begin
          grant            = 1'b1;
          req_ready[pick]  = 1'b1;
          state_d          = sel_we ? WR : RA;
        end
      end
      WR: begin
        if (aw_fin && w_fin) state_d = WB;
      end
      WB: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) state_d = RSP;
      end
      RA: begin
        if (M_AXI_ARREADY) state_d = RD;
      end
      RD: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) state_d = RSP;
      end
      RSP: begin
        rsp_valid[gnt_q] = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any transaction in flight.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Grant bookkeeping, AXI request registers and the completion result.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      last_q       <= 1'b1;
      gnt_q        <= 1'b0;
      aw_vld_q     <= 1'b0;
      w_vld_q      <= 1'b0;
      ar_vld_q     <= 1'b0;
      M_AXI_AWADDR <= '0;
      M_AXI_WDATA  <= '0;
      M_AXI_ARADDR <= '0;
      rsp_rdata    <= '0;
      rsp_resp     <= 2'b00;
    end else begin
      if (grant) begin
        gnt_q  <= pick;
        last_q <= pick;
        if (sel_we) begin
          M_AXI_AWADDR <= sel_addr;
          M_AXI_WDATA  <= sel_wdata;
          aw_vld_q     <= 1'b1;
          w_vld_q      <= 1'b1;
        end else begin
          M_AXI_ARADDR <= sel_addr;
          ar_vld_q     <= 1'b1;
        end
      end
      if (state_q == WR) begin
        if (aw_vld_q && M_AXI_AWREADY) aw_vld_q <= 1'b0;
        if (w_vld_q && M_AXI_WREADY)   w_vld_q  <= 1'b0;
      end
      if ((state_q == RA) && M_AXI_ARREADY) ar_vld_q <= 1'b0;
      if ((state_q == WB) && M_AXI_BVALID) begin
        rsp_rdata <= '0;
        rsp_resp  <= M_AXI_BRESP;
      end
      if ((state_q == RD) && M_AXI_RVALID) begin
        rsp_rdata <= M_AXI_RDATA;
        rsp_resp  <= M_AXI_RRESP;
      end
    end
  end

endmodule

// File: tb/tb_amacv2_axil_arbiter.sv
// tb_amacv2_axil_arbiter: directed and randomized bench for the two-requester
// AXI4-Lite arbiter, with a register-file slave of configurable latency and a
// transaction-level reference model of grant order and completion results.
module tb_amacv2_axil_arbiter;

  logic        clk = 1'b0;
  logic        ARESETN;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid, rsp_resp;
  logic [63:0] req_addr, req_wdata;
  logic [31:0] rsp_rdata;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } cmd_t;

  // slave configuration
  int          cfg_aw_delay, cfg_w_delay, cfg_ar_delay, cfg_b_delay;
  logic [1:0]  cfg_resp;

  // reference model and bookkeeping
  cmd_t        q0[$], q1[$];
  logic [31:0] ref_mem [16];
  bit          ref_last;
  bit          outstanding;
  cmd_t        out_cmd;
  bit          out_g;
  logic [31:0] exp_rdata;
  logic [1:0]  exp_resp;
  int          grant_n;
  bit          aw_done, w_done, ar_done, b_done, r_done, rsp_due;
  int          aw_hi, w_hi, ar_hi, n_ar;
  logic [1:0]  grant_log[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  amacv2_axil_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .ACLK(clk), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  // ---------------- register-file slave ----------------
  logic [31:0] smem [16];
  int          aw_cnt, w_cnt, ar_cnt, b_cnt;
  logic        got_aw, got_w, b_pend;
  logic [31:0] lat_awaddr, lat_wdata, eff_awaddr, eff_wdata;
  logic        aw_hs, w_hs, ar_hs;

  assign awready    = awvalid && (aw_cnt >= cfg_aw_delay);
  assign wready     = wvalid  && (w_cnt  >= cfg_w_delay);
  assign arready    = arvalid && (ar_cnt >= cfg_ar_delay);
  assign aw_hs      = awvalid && awready;
  assign w_hs       = wvalid && wready;
  assign ar_hs      = arvalid && arready;
  assign eff_awaddr = aw_hs ? awaddr : lat_awaddr;
  assign eff_wdata  = w_hs ? wdata : lat_wdata;

  // Slave: ready after a programmable wait, B/R one cycle after the last handshake (plus b delay)
  always @(posedge clk) begin
    if (!ARESETN) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0;
      got_aw <= 1'b0; got_w <= 1'b0; b_pend <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      if (aw_hs) lat_awaddr <= awaddr;
      if (w_hs)  lat_wdata  <= wdata;
      if ((got_aw || aw_hs) && (got_w || w_hs)) begin
        smem[eff_awaddr[5:2]] <= eff_wdata;
        got_aw <= 1'b0;
        got_w  <= 1'b0;
        bresp  <= cfg_resp;
        if (cfg_b_delay == 0) bvalid <= 1'b1;
        else begin b_pend <= 1'b1; b_cnt <= 1; end
      end else begin
        if (aw_hs) got_aw <= 1'b1;
        if (w_hs)  got_w  <= 1'b1;
      end
      if (b_pend) begin
        if (b_cnt >= cfg_b_delay) begin bvalid <= 1'b1; b_pend <= 1'b0; end
        else b_cnt <= b_cnt + 1;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (ar_hs) begin
        rvalid <= 1'b1;
        rdata  <= smem[araddr[5:2]];
        rresp  <= cfg_resp;
      end else if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int max_cycles, input bit zw, input bit cont);
    int         n;
    int         prev_grant;
    bit         any_done;
    logic [31:0] last_rdata;
    logic [1:0] last_resp;
    logic [1:0] v, exp_rdy;
    bit         g;
    cmd_t       c0, c1;
    n = 0; prev_grant = -1; any_done = 0; last_rdata = '0; last_resp = '0;
    while ((q0.size() != 0 || q1.size() != 0 || outstanding) && n < max_cycles) begin
      v[0] = (q0.size() != 0) && (cont || ($urandom_range(3) != 0));
      v[1] = (q1.size() != 0) && (cont || ($urandom_range(3) != 0));
      if (q0.size() != 0) c0 = q0[0];
      else begin c0.we = 1'($urandom_range(1)); c0.addr = $urandom; c0.data = $urandom; end
      if (q1.size() != 0) c1 = q1[0];
      else begin c1.we = 1'($urandom_range(1)); c1.addr = $urandom; c1.data = $urandom; end
      req_valid = v;
      req_we    = {c1.we, c0.we};
      req_addr  = {c1.addr, c0.addr};
      req_wdata = {c1.data, c0.data};
      @(negedge clk);
      chk("awvalid", awvalid, outstanding && out_cmd.we && !aw_done);
      chk("wvalid",  wvalid,  outstanding && out_cmd.we && !w_done);
      chk("arvalid", arvalid, outstanding && !out_cmd.we && !ar_done);
      chk("bready",  bready,  outstanding && out_cmd.we && aw_done && w_done && !b_done);
      chk("rready",  rready,  outstanding && !out_cmd.we && ar_done && !r_done);
      if (awvalid) begin aw_hi++; chk("awaddr", awaddr, out_cmd.addr); end
      if (wvalid)  begin w_hi++;  chk("wdata",  wdata,  out_cmd.data); end
      if (arvalid) begin ar_hi++; chk("araddr", araddr, out_cmd.addr); end
      g = 1'b0;
      exp_rdy = 2'b00;
      if (!outstanding && v != 2'b00) begin
        g = (v == 2'b11) ? ~ref_last : v[1];
        exp_rdy = g ? 2'b10 : 2'b01;
      end
      chk("req_ready", req_ready, exp_rdy);
      chk("rsp_valid", rsp_valid, (outstanding && rsp_due) ? (out_g ? 2'b10 : 2'b01) : 2'b00);
      if (outstanding && rsp_due) begin
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_resp", rsp_resp, exp_resp);
        if (zw) chk("rsp_latency", n - grant_n, 3);
        if (out_cmd.we) begin
          chk("aw_cycles", aw_hi, cfg_aw_delay + 1);
          chk("w_cycles", w_hi, cfg_w_delay + 1);
        end else begin
          chk("ar_cycles", ar_hi, cfg_ar_delay + 1);
          chk("ar_count", n_ar, 1);
        end
        last_rdata = exp_rdata; last_resp = exp_resp; any_done = 1;
        outstanding = 0;
      end
      if (req_ready != 2'b00) grant_log.push_back(req_ready);
      if (exp_rdy != 2'b00) begin
        if (g) out_cmd = q1.pop_front();
        else   out_cmd = q0.pop_front();
        out_g = g; ref_last = g; outstanding = 1; grant_n = n;
        aw_done = 0; w_done = 0; ar_done = 0; b_done = 0; r_done = 0; rsp_due = 0;
        aw_hi = 0; w_hi = 0; ar_hi = 0; n_ar = 0;
        exp_resp = cfg_resp;
        if (out_cmd.we) begin
          exp_rdata = '0;
          ref_mem[out_cmd.addr[5:2]] = out_cmd.data;
        end else exp_rdata = ref_mem[out_cmd.addr[5:2]];
        if (zw && cont && prev_grant >= 0) chk("b2b_period", n - prev_grant, 4);
        prev_grant = n;
      end
      if (outstanding) begin
        if (awvalid && awready) aw_done = 1;
        if (wvalid && wready)   w_done = 1;
        if (arvalid && arready) begin ar_done = 1; n_ar++; end
        if (bvalid && bready)   begin b_done = 1; rsp_due = 1; end
        if (rvalid && rready)   begin r_done = 1; rsp_due = 1; end
      end
      @(posedge clk); #1;
      n++;
    end
    chk("run_drain", q0.size() + q1.size() + int'(outstanding), 0);
    if (any_done) begin
      chk("rsp_rdata_hold", rsp_rdata, last_rdata);
      chk("rsp_resp_hold", rsp_resp, last_resp);
    end
    req_valid = 2'b00;
  endtask

  function automatic cmd_t mk(input logic we, input logic [31:0] addr, input logic [31:0] data);
    cmd_t c;
    c.we = we; c.addr = addr; c.data = data;
    return c;
  endfunction

  // Global time bound in case a wait is never satisfied
  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Directed steps followed by randomized rounds
  initial begin
    int n;
    cfg_aw_delay = 0; cfg_w_delay = 0; cfg_ar_delay = 0; cfg_b_delay = 0; cfg_resp = 2'b00;
    ref_last = 1'b1; outstanding = 0;
    ARESETN   = 1'b0;
    req_valid = 2'b11; req_we = 2'b11;
    req_addr  = {32'h0000_0014, 32'h0000_0010}; req_wdata = {32'h5555_5555, 32'hAAAA_AAAA};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {req_ready, rsp_valid, rsp_resp, awvalid, wvalid, arvalid, bready, rready}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_addr", {awaddr, araddr}, 0);
    chk("rst_wdata", wdata, 0);
    req_valid = 2'b00;
    @(negedge clk); ARESETN = 1'b1;
    @(posedge clk); #1;

    // both requesters continuously valid: alternating grants, requester 0 first
    for (int i = 4; i < 16; i += 2) begin
      q0.push_back(mk(1'b1, i * 4, 32'h1000_0000 + i));
      q1.push_back(mk(1'b1, (i + 1) * 4, 32'h2000_0000 + i + 1));
    end
    grant_log.delete();
    run(200, 1'b1, 1'b1);
    chk("grant_count", grant_log.size(), 12);
    for (int i = 0; i < grant_log.size(); i++)
      chk("grant_order", grant_log[i], (i % 2 == 0) ? 2'b01 : 2'b10);

    // req0 writes 1..4 to 0x0..0xC, then reads them back in order
    for (int i = 0; i < 4; i++) q0.push_back(mk(1'b1, i * 4, i + 1));
    for (int i = 0; i < 4; i++) q0.push_back(mk(1'b0, i * 4, 32'h0));
    run(200, 1'b1, 1'b1);

    // AWREADY late by three cycles, WREADY immediate
    cfg_aw_delay = 3;
    q1.push_back(mk(1'b1, 32'h30, 32'hCAFE_0030));
    run(100, 1'b0, 1'b1);
    cfg_aw_delay = 0;

    // read returns SLVERR with data 0xDEADBEEF; only one AR issued
    q1.push_back(mk(1'b1, 32'h20, 32'hDEAD_BEEF));
    run(100, 1'b1, 1'b1);
    cfg_resp = 2'b10;
    q0.push_back(mk(1'b0, 32'h20, 32'h0));
    run(100, 1'b1, 1'b1);
    chk("rd_err_resp", rsp_resp, 2'b10);
    chk("rd_err_data", rsp_rdata, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_second_ar", arvalid, 1'b0);
    end
    @(posedge clk); #1;

    // randomized rounds: random slave latency, response codes and request mix
    for (int r = 0; r < 8; r++) begin
      cfg_aw_delay = $urandom_range(3); cfg_w_delay = $urandom_range(3);
      cfg_ar_delay = $urandom_range(3); cfg_b_delay = $urandom_range(2);
      cfg_resp     = 2'($urandom_range(3));
      for (int i = 0; i < 4; i++) begin
        q0.push_back(mk(1'($urandom_range(1)), {26'd0, 4'($urandom_range(15)), 2'b00}, $urandom));
        q1.push_back(mk(1'($urandom_range(1)), {26'd0, 4'($urandom_range(15)), 2'b00}, $urandom));
      end
      run(600, 1'b0, 1'b0);
    end
    cfg_aw_delay = 0; cfg_w_delay = 0; cfg_ar_delay = 0; cfg_resp = 2'b00;

    // reset for one cycle while waiting for B: transaction dropped, service resumes
    cfg_b_delay = 6;
    req_valid = 2'b01; req_we = 2'b01;
    req_addr  = {32'h0, 32'h0000_0008}; req_wdata = {32'h0, 32'hA5A5_0008};
    @(negedge clk);
    chk("abort_grant", req_ready, 2'b01);
    ref_mem[2] = 32'hA5A5_0008;
    @(posedge clk); #1;
    req_valid = 2'b00;
    n = 0;
    do begin @(negedge clk); n++; end while (!bready && n < 20);
    chk("wb_reached", bready, 1'b1);
    ARESETN = 1'b0;
    @(posedge clk); #1;
    chk("abort_ctrl", {req_ready, rsp_valid, rsp_resp, awvalid, wvalid, arvalid, bready, rready}, 0);
    chk("abort_rdata", rsp_rdata, 0);
    chk("abort_addr", {awaddr, araddr}, 0);
    chk("abort_wdata", wdata, 0);
    @(negedge clk); ARESETN = 1'b1;
    ref_last = 1'b1;
    cfg_b_delay = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", rsp_valid, 2'b00);
    end
    @(posedge clk); #1;
    q0.push_back(mk(1'b0, 32'h8, 32'h0));
    run(100, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/amacv2_axil_arbiter.md
AMACV2_AXIL_ARBITER -- requirements
Module: amacv2_axil_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning AXI4-Lite address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning AXI4-Lite data width; only 32 is supported.
REQ-003 SHALL have port ACLK  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port ARESETN  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  in  2  per-requester command valid (bit i = requester i).
REQ-006 SHALL have port req_ready  out  2  per-requester command accept, one-hot or zero.
REQ-007 SHALL have port req_we  in  2  per-requester type: 1 = write, 0 = read.
REQ-008 SHALL have port req_addr  in  2*ADDR_WIDTH  per-requester byte address (requester i at slice i).
REQ-009 SHALL have port req_wdata  in  2*DATA_WIDTH  per-requester write data (requester i at slice i).
REQ-010 SHALL have port rsp_valid  out  2  one-cycle completion pulse to the granted requester, one-hot or zero.
REQ-011 SHALL have port rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
REQ-012 SHALL have port rsp_resp  out  2  BRESP or RRESP of the completed transaction.
REQ-013 SHALL have AXI4-Lite master ports M_AXI_AWADDR(out,AW), M_AXI_AWVALID(out,1), M_AXI_AWREADY(in,1): write address channel.
REQ-014 SHALL have M_AXI_WDATA(out,DW), M_AXI_WVALID(out,1), M_AXI_WREADY(in,1): write data channel; strobes all-ones, PROT 3'b000, tied at integration.
REQ-015 SHALL have M_AXI_BRESP(in,2), M_AXI_BVALID(in,1), M_AXI_BREADY(out,1): write response channel.
REQ-016 SHALL have M_AXI_ARADDR(out,AW), M_AXI_ARVALID(out,1), M_AXI_ARREADY(in,1): read address channel.
REQ-017 SHALL have M_AXI_RDATA(in,DW), M_AXI_RRESP(in,2), M_AXI_RVALID(in,1), M_AXI_RREADY(out,1): read data channel.

Function
REQ-018 SHALL implement FSM states IDLE, WR, WB, RA, RD, RSP; exactly one AXI transaction outstanding at any time.
REQ-019 In IDLE, SHALL grant one valid requester: if one valid, grant it; if both valid, grant the one not granted last (round-robin).
REQ-020 SHALL assert req_ready[g] for exactly the grant cycle, capture addr/wdata/we of g that cycle, and go to WR (we=1) or RA (we=0); req_ready=0 in all other states.
REQ-021 Requesters SHALL hold valid and payload until req_ready; an ungranted requester dropping valid is ignored, no side effect.
REQ-022 In WR, SHALL assert AWVALID and WVALID together from the cycle after grant, each deasserted independently the cycle after its own handshake, AWADDR/WDATA stable while valid; leave WR to WB when both handshakes are done, including same-cycle.
REQ-023 In WB, SHALL hold BREADY=1; on BVALID capture BRESP, set rdata=0, go to RSP.
REQ-024 In RA, SHALL hold ARVALID with stable ARADDR until ARREADY, then go to RD; in RD, hold RREADY=1, on RVALID capture RDATA/RRESP, go to RSP.
REQ-025 In RSP, SHALL pulse rsp_valid[g] for one cycle and return to IDLE; rsp_rdata/rsp_resp hold until the next RSP.
REQ-026 VALID signals SHALL never be withdrawn before READY; BREADY/RREADY SHALL be 0 outside WB/RD.
REQ-027 SHALL pass SLVERR/DECERR unmodified to rsp_resp, with no retry.
REQ-028 With a zero-wait slave (READY=1, B/R one cycle after handshake), rsp_valid SHALL rise 3 cycles after req_ready; back-to-back transactions SHALL take 4 cycles each.

Reset
REQ-029 While ARESETN=0 at a rising edge, SHALL go to IDLE and drive all outputs to 0 (VALIDs, BREADY, RREADY, req_ready, rsp_valid, rsp_rdata, rsp_resp, AWADDR, WDATA, ARADDR); last-grant SHALL be set so requester 0 wins first.
REQ-030 Reset mid-transaction SHALL drop the transaction, with no rsp_valid for it; service SHALL resume normally after ARESETN=1.

Verification
REQ-031 Req0 write addr 0x0 data 0x1, zero-wait slave -> AWADDR=0x0, WDATA=0x1, rsp_valid=2'b01 three cycles after req_ready, rsp_resp=2'b00.
REQ-032 Register-file slave; req0 writes 0x0,0x4,0x8,0xC data 1..4, then reads the same addresses -> rsp_rdata 0x1..0x4 in order.
REQ-033 Both requesters continuously valid for 4 transactions -> grant order 0,1,0,1; req_ready never 2'b11.
REQ-034 AWREADY delayed 3 cycles, WREADY=1 -> WVALID high 1 cycle, AWVALID high 4 cycles with stable AWADDR, BREADY only after both handshakes.
REQ-035 Read, slave returns RRESP=2'b10 and RDATA=0xDEADBEEF -> rsp_resp=2'b10, rsp_rdata=0xDEADBEEF, no second AR issued.
REQ-036 ARESETN=0 for one cycle in WB -> next cycle all outputs 0, no rsp_valid; the following request completes normally.
